// File: rtl/lm_sm_sequencer.sv
// LM/SM multicycle sequencer: walks an 8-bit register list lowest-bit first,
// emitting one register/memory-word pair per accepted step.
module lm_sm_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_store,
    input  logic [7:0]  reg_list,
    input  logic [15:0] base_addr,
    input  logic        step_ready,
    output logic        busy,
    output logic        step_valid,
    output logic [2:0]  reg_addr,
    output logic [15:0] mem_addr,
    output logic        mem_we,
    output logic        regw,
    output logic        done
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_XFER = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  state_q;
    logic [7:0]  mask_q;
    logic [15:0] addr_q;
    logic        is_store_q;
    logic [2:0]  low_idx;
    logic [7:0]  mask_clr;

    // Scan high-to-low so the lowest set bit wins (R0 first).
    always_comb begin
        low_idx = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (mask_q[i]) low_idx = 3'(i);
    end

    assign mask_clr   = mask_q & (mask_q - 8'd1);
    assign step_valid = (state_q == S_XFER);
    assign busy       = (state_q == S_XFER) || (state_q == S_DONE);
    assign done       = (state_q == S_DONE);
    // Gated so nothing stale leaks onto the register file ports outside a step.
    assign reg_addr   = step_valid ? low_idx : 3'd0;
    assign mem_addr   = step_valid ? addr_q  : 16'd0;
    assign mem_we     = step_valid & is_store_q;
    assign regw       = step_valid & step_ready & ~is_store_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            mask_q     <= 8'd0;
            addr_q     <= 16'd0;
            is_store_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        mask_q     <= reg_list;
                        addr_q     <= base_addr;
                        is_store_q <= is_store;
                        state_q    <= (reg_list != 8'd0) ? S_XFER : S_DONE;
                    end
                end
                S_XFER: begin
                    if (step_ready) begin
                        mask_q <= mask_clr;
                        addr_q <= addr_q + 16'd1;
                        if (mask_clr == 8'd0) state_q <= S_DONE;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Scoreboard bench: stimulus pushes expected steps, a monitor pops on each step.
module tb_lm_sm_sequencer;
    logic        clk, reset, start, is_store, step_ready;
    logic [7:0]  reg_list;
    logic [15:0] base_addr;
    logic        busy, step_valid, mem_we, regw, done;
    logic [2:0]  reg_addr;
    logic [15:0] mem_addr;

    typedef struct {
        logic [2:0]  r;
        logic [15:0] a;
        logic        we;
        logic        rw;
    } step_t;

    step_t exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;
    int regw_cnt = 0;

    lm_sm_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .is_store(is_store),
        .reg_list(reg_list), .base_addr(base_addr), .step_ready(step_ready),
        .busy(busy), .step_valid(step_valid), .reg_addr(reg_addr),
        .mem_addr(mem_addr), .mem_we(mem_we), .regw(regw), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expected step per accepted transfer, peeks while stalled.
    always @(negedge clk) begin
        if (step_valid && step_ready) begin
            if (exp_q.size() == 0) begin
                cmp("unexpected_step", {13'd0, reg_addr, mem_addr}, 32'hDEAD);
            end else begin
                step_t e;
                e = exp_q.pop_front();
                cmp("step", {12'd0, reg_addr, mem_addr, mem_we, regw},
                    {12'd0, e.r, e.a, e.we, e.rw});
            end
            if (regw) regw_cnt++;
        end else if (step_valid) begin
            if (exp_q.size() == 0)
                cmp("unexpected_stall", {13'd0, reg_addr, mem_addr}, 32'hDEAD);
            else
                cmp("stall_hold", {12'd0, reg_addr, mem_addr, mem_we, regw},
                    {12'd0, exp_q[0].r, exp_q[0].a, exp_q[0].we, 1'b0});
        end else begin
            cmp("idle_strobes", {30'd0, mem_we, regw}, 32'd0);
        end
    end

    task automatic issue(input logic st, input logic [7:0] lst, input logic [15:0] base);
        logic [15:0] a;
        @(posedge clk); #1;
        start = 1'b1; is_store = st; reg_list = lst; base_addr = base;
        a = base;
        for (int i = 0; i < 8; i++) begin
            if (lst[i]) begin
                exp_q.push_back('{r: 3'(i), a: a, we: st, rw: ~st});
                a = a + 16'd1;
            end
        end
        @(posedge clk); #1;
        start = 1'b0; reg_list = 8'h5A; base_addr = 16'hBEEF; is_store = ~st;
    endtask

    // Called in cycle 1 after the accepting edge; rdy_pat bit c-1 drives step_ready in cycle c.
    task automatic wait_done(input string name, input int exp_cyc, input logic [63:0] rdy_pat);
        int busy_cnt = 0;
        bit seen = 0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            step_ready = rdy_pat[c-1];
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                seen = 1;
                cmp({name, "_done_cycle"}, c, exp_cyc);
                cmp({name, "_busy_cycles"}, busy_cnt, exp_cyc);
            end
            @(posedge clk); #1;
        end
        if (!seen) cmp({name, "_timeout"}, 0, 1);
        step_ready = 1'b1;
        @(negedge clk);
        cmp({name, "_idle_after"}, {30'd0, busy, done}, 0);
        cmp({name, "_queue_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        int rc;
        reset = 1'b0; start = 1'b0; is_store = 1'b0; reg_list = 8'd0;
        base_addr = 16'd0; step_ready = 1'b1;
        #12;
        cmp("reset_outputs", {8'd0, busy, step_valid, reg_addr, mem_addr, mem_we, regw, done}, 0);
        @(posedge clk); #1 reset = 1'b1;

        // LM 0,2,5,7 from 0x40
        issue(1'b0, 8'b1010_0101, 16'h0040);
        rc = regw_cnt;
        wait_done("lm_a5", 5, '1);
        cmp("lm_a5_regw_cnt", regw_cnt - rc, 4);

        // SM all regs with address wrap
        issue(1'b1, 8'hFF, 16'hFFFE);
        rc = regw_cnt;
        wait_done("sm_ff", 9, '1);
        cmp("sm_ff_regw_cnt", regw_cnt - rc, 0);

        // Backpressure: first step stalled 2 cycles
        step_ready = 1'b0;
        issue(1'b0, 8'h06, 16'h0200);
        rc = regw_cnt;
        wait_done("bp", 5, ~64'h3);
        cmp("bp_regw_cnt", regw_cnt - rc, 2);

        // Empty list
        issue(1'b0, 8'h00, 16'h0300);
        wait_done("empty", 1, '1);

        // Starts during XFER and DONE are ignored
        issue(1'b0, 8'h0F, 16'h0100);
        @(posedge clk); #1;
        start = 1'b1; is_store = 1'b1; reg_list = 8'hF0; base_addr = 16'h9000;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b1; reg_list = 8'h81; base_addr = 16'h7000;
        @(negedge clk);
        cmp("ign_done", done, 1);
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cmp("ign_no_restart", {30'd0, busy, step_valid}, 0);
        end
        cmp("ign_queue_empty", exp_q.size(), 0);

        // Reset after the second step of an SM 0xFF
        issue(1'b1, 8'hFF, 16'h1000);
        @(posedge clk); #1;
        @(posedge clk); #1;
        cmp("rst_pre_queue", exp_q.size(), 6);
        #2 reset = 1'b0;
        #1;
        cmp("rst_async_outputs", {8'd0, busy, step_valid, reg_addr, mem_addr, mem_we, regw, done}, 0);
        exp_q.delete();
        @(posedge clk); @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        cmp("rst_idle", {30'd0, busy, step_valid}, 0);
        issue(1'b1, 8'h03, 16'h0300);
        wait_done("post_rst", 3, '1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
